mem_checker_core: RTL and testbench
===================================

// Module: mem_checker_core
// PURPOSE
//  Single-clock, parametrised write/read-back memory checker core: writes a generated pattern over
//  a word range via an Avalon-MM burst master, reads it back with up to MAX_OUTSTANDING read bursts
//  in flight, compares in order, reports pass/fail, error count and first-error capture.
//  Successor to the split control/transmitter/compare datapath; sits between CSR logic and memory.
// PARAMETERS
//  AMM_DATA_W       128  memory data width, bits (multiple of 32); DATA_B_W = AMM_DATA_W/8
//  AMM_ADDR_W       31   word address width
//  AMM_BURST_W      11   burstcount width
//  MAX_OUTSTANDING  4    max read bursts issued but not fully returned (1..16)
//  ERR_CNT_W        16   mismatch counter width
// PORTS
//  clk_i            in   1            clock
//  rst_i            in   1            asynchronous reset, active-high
//  start_i          in   1            start pulse; ignored while busy_o=1
//  base_addr_i      in   AMM_ADDR_W   first word address
//  length_i         in   32           words to test
//  burst_i          in   AMM_BURST_W  max words per burst; 0 treated as 1
//  mode_i           in   2            0 fixed, 1 address, 2 LFSR, 3 inverted address
//  pattern_i        in   32           fixed word (mode 0) / LFSR seed (mode 2; 0 -> 32'h1)
//  busy_o           out  1            test in progress
//  done_o           out  1            one-cycle pulse at test end
//  pass_o           out  1            1 = zero mismatches; valid from done_o until next start
//  err_cnt_o        out  ERR_CNT_W    mismatched words, saturating
//  err_addr_o       out  AMM_ADDR_W   address of first mismatch
//  err_data_o       out  AMM_DATA_W   read data of first mismatch
//  exp_data_o       out  AMM_DATA_W   expected data of first mismatch
//  address_o, read_o, write_o, writedata_o, burstcount_o, byteenable_o  out  Avalon-MM master
//  waitrequest_i, readdatavalid_i  in 1; readdata_i in AMM_DATA_W       Avalon-MM master
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0; asserted mid-test drops read_o/write_o at once.
//  - start_i in IDLE latches all config inputs; busy_o=1 next cycle; length_i=0 -> DONE directly,
//    pass_o=1, no bus traffic.
//  - FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE (1 cycle, done_o=1, busy_o=0 after) -> IDLE.
//  - Pattern per word addr A, 32-bit unit replicated over data width: mode0 pattern; mode1 A
//    zero-extended; mode2 32-bit Galois LFSR (taps 32,22,2,1) stepped once per word, restarted
//    from seed for the read phase; mode3 ~A.
//  - WRITE: burstcount = min(burst, remaining); address_o/burstcount_o held for whole burst;
//    beat advances only when write_o=1 and waitrequest_i=0; next burst follows back-to-back.
//    byteenable_o all ones. Last beat accepted -> READ.
//  - READ: read_o held until waitrequest_i=0 (one accepted cycle per burst); new burst issued only
//    while outstanding < MAX_OUTSTANDING; outstanding counter += 1 on accept, -= 1 on last word of
//    a burst; simultaneous accept and completion leave it unchanged. All issued -> DRAIN.
//  - DRAIN: wait for outstanding = 0 -> DONE.
//  - Compare: responses in order; each readdatavalid_i word compared to regenerated expected
//    data; mismatch -> err_cnt_o+1 (sticks at all ones); first mismatch latches err_addr_o,
//    err_data_o, exp_data_o; later mismatches never overwrite. Compare result registered 1 cycle.
//  - Address counter wraps modulo 2^AMM_ADDR_W; error capture reports wrapped address.
//  - readdatavalid_i outside READ/DRAIN ignored; start_i while busy ignored, no side effects.
//  - New start clears err_cnt_o, capture registers and pass_o.
// CONFIGURATION
//  MEM_CHECKER_STOP_ON_ERR_EN defined: after the first mismatch no further read bursts issued;
//    FSM goes to DRAIN, in-flight data still compared/counted, then DONE with pass_o=0.
//  Not defined: test always runs the full length regardless of mismatches.
// TESTING
//  1 mode0, pattern 32'hA5A5_5A5A, base 0, length 64, burst 8, no waitrequest -> 8 write and
//    8 read bursts, done_o once, pass_o=1, err_cnt_o=0.
//  2 mode1, length 10, burst 4 -> burstcounts 4,4,2 in both phases; word 9 data = 32'h9 replicated.
//  3 slave corrupts word at addr 0x25 in mode2, length 64 -> err_cnt_o=1, err_addr_o=0x25,
//    exp_data_o = LFSR value 37, pass_o=0.
//  4 MAX_OUTSTANDING=2, read latency 20 cycles -> read_o never has a 3rd unreturned burst issued;
//    random waitrequest, all data compared.
//  5 base 0x7FFF_FFFE, length 4, mode1 -> addresses 0x7FFF_FFFE, 0x7FFF_FFFF, 0, 1; pass_o=1.
//  6 rst_i mid-WRITE -> outputs 0 same cycle; new start after reset runs clean; with
//    MEM_CHECKER_STOP_ON_ERR_EN, error in burst 1 of 8 -> no read_o after drain, done_o, err_cnt_o>=1.

Source files
------------

// File: rtl/mem_checker_core.sv
// mem_checker_core: Avalon-MM write/read-back memory checker.
// Optional stop-on-first-error via MEM_CHECKER_STOP_ON_ERR_EN.
//
// Ports: clk_i/rst_i (async, active-high); start_i and config
// (base_addr_i, length_i, burst_i, mode_i, pattern_i); status
// (busy_o, done_o, pass_o, err_cnt_o, err_addr_o, err_data_o,
// exp_data_o); Avalon-MM burst master (address_o, read_o,
// write_o, writedata_o, burstcount_o, byteenable_o,
// waitrequest_i, readdatavalid_i, readdata_i).
module mem_checker_core #(
  parameter int AMM_DATA_W      = 128,
  parameter int AMM_ADDR_W      = 31,
  parameter int AMM_BURST_W     = 11,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AMM_ADDR_W-1:0]  base_addr_i,
  input  logic [31:0]            length_i,
  input  logic [AMM_BURST_W-1:0] burst_i,
  input  logic [1:0]             mode_i,
  input  logic [31:0]            pattern_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o,
  output logic [AMM_ADDR_W-1:0]  err_addr_o,
  output logic [AMM_DATA_W-1:0]  err_data_o,
  output logic [AMM_DATA_W-1:0]  exp_data_o,
  output logic [AMM_ADDR_W-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [AMM_DATA_W-1:0]  writedata_o,
  output logic [AMM_BURST_W-1:0] burstcount_o,
  output logic [AMM_DATA_W/8-1:0] byteenable_o,
  input  logic                   waitrequest_i,
  input  logic                   readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]  readdata_i
);

  localparam int DATA_B_W = AMM_DATA_W / 8;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = AMM_ADDR_W;
  localparam int BW = AMM_BURST_W;
  localparam int DW = AMM_DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    mode_q;
  logic [31:0]   pat_q;
  logic [31:0]   seed_q;
  logic [AW-1:0] base_q;
  logic [31:0]   len_q;
  logic [BW-1:0] burst_q;

  logic [AW-1:0] addr_q;
  logic [BW-1:0] bc_q;
  logic [31:0]   rem_q;
  logic [BW-1:0] beat_q;
  logic [AW-1:0] wa_q;
  logic [31:0]   lfsr_q;

  logic [OW-1:0] osd_q;
  logic          hold_q;
  logic [BW-1:0] rx_cnt_q;
  logic [31:0]   rx_left_q;

  logic          cmp_v_q;
  logic          cmp_mis_q;
  logic [AW-1:0] cmp_addr_q;
  logic [DW-1:0] cmp_rd_q;
  logic [DW-1:0] cmp_exp_q;

  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [AW-1:0] err_addr_q;
  logic [DW-1:0] err_data_q;
  logic [DW-1:0] exp_data_q;
  logic          pass_q;

  logic [31:0]   pat32;
  logic [DW-1:0] pat_word;
  logic [BW-1:0] burst1;
  logic [31:0]   seed1;
  logic          wr_acc, rd_acc;
  logic          wr_last, rx, rx_last;
  logic          stop_req;
  logic          last_issue;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003)
                     : (s >> 1);
  endfunction

  function automatic logic [BW-1:0] bmin(
    input logic [31:0]   r,
    input logic [BW-1:0] b
  );
    bmin = (r < 32'(b)) ? r[BW-1:0] : b;
  endfunction

  assign burst1 = (burst_i == '0) ? BW'(1) : burst_i;
  assign seed1  = (pattern_i == '0) ? 32'h1 : pattern_i;

  always_comb begin
    pat32 = pat_q;
    unique case (mode_q)
      2'd0: pat32 = pat_q;
      2'd1: pat32 = 32'(wa_q);
      2'd2: pat32 = lfsr_q;
      2'd3: pat32 = ~32'(wa_q);
    endcase
  end

  assign pat_word = {(DW/32){pat32}};

`ifdef MEM_CHECKER_STOP_ON_ERR_EN
  assign stop_req = (err_cnt_q != '0) ||
                    (cmp_v_q && cmp_mis_q);
`else
  assign stop_req = 1'b0;
`endif

  // read_o must stay up once raised until accepted
  always_comb begin
    write_o = (state_q == S_WRITE);
    read_o  = (state_q == S_READ) &&
              (hold_q ||
               ((osd_q < OW'(MAX_OUTSTANDING)) &&
                !stop_req));
  end

  assign wr_acc  = write_o && !waitrequest_i;
  assign rd_acc  = read_o && !waitrequest_i;
  assign wr_last = wr_acc && (beat_q == bc_q - BW'(1));
  assign last_issue = (rem_q == 32'(bc_q));
  assign rx = readdatavalid_i && (osd_q != '0) &&
              ((state_q == S_READ) ||
               (state_q == S_DRAIN));
  assign rx_last = rx && (rx_cnt_q == BW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start_i)
          state_d = (length_i == '0) ? S_DONE : S_WRITE;
      S_WRITE:
        if (wr_last && last_issue)
          state_d = S_READ;
      S_READ:
        if (rd_acc && last_issue)
          state_d = S_DRAIN;
        else if (stop_req && !read_o)
          state_d = S_DRAIN;
      S_DRAIN:
        if (osd_q == '0 && !cmp_v_q)
          state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      pat_q      <= '0;
      seed_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      bc_q       <= '0;
      rem_q      <= '0;
      beat_q     <= '0;
      wa_q       <= '0;
      lfsr_q     <= '0;
      osd_q      <= '0;
      hold_q     <= 1'b0;
      rx_cnt_q   <= '0;
      rx_left_q  <= '0;
      cmp_v_q    <= 1'b0;
      cmp_mis_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_rd_q   <= '0;
      cmp_exp_q  <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      exp_data_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= read_o && waitrequest_i;
      cmp_v_q <= rx;

      if (state_q == S_IDLE && start_i) begin
        mode_q     <= mode_i;
        pat_q      <= pattern_i;
        seed_q     <= seed1;
        base_q     <= base_addr_i;
        len_q      <= length_i;
        burst_q    <= burst1;
        addr_q     <= base_addr_i;
        rem_q      <= length_i;
        bc_q       <= bmin(length_i, burst1);
        beat_q     <= '0;
        wa_q       <= base_addr_i;
        lfsr_q     <= seed1;
        osd_q      <= '0;
        err_cnt_q  <= '0;
        err_addr_q <= '0;
        err_data_q <= '0;
        exp_data_q <= '0;
        pass_q     <= (length_i == '0);
      end

      if (wr_acc) begin
        wa_q   <= wa_q + AW'(1);
        lfsr_q <= lfsr_step(lfsr_q);
        beat_q <= beat_q + BW'(1);
        if (wr_last) begin
          beat_q <= '0;
          if (last_issue) begin
            // read phase replays the sequence
            addr_q    <= base_q;
            rem_q     <= len_q;
            bc_q      <= bmin(len_q, burst_q);
            wa_q      <= base_q;
            lfsr_q    <= seed_q;
            rx_left_q <= len_q;
            rx_cnt_q  <= bmin(len_q, burst_q);
          end else begin
            addr_q <= addr_q + AW'(bc_q);
            rem_q  <= rem_q - 32'(bc_q);
            bc_q   <= bmin(rem_q - 32'(bc_q), burst_q);
          end
        end
      end

      if (rd_acc) begin
        addr_q <= addr_q + AW'(bc_q);
        rem_q  <= rem_q - 32'(bc_q);
        bc_q   <= bmin(rem_q - 32'(bc_q), burst_q);
      end

      if (rx) begin
        wa_q       <= wa_q + AW'(1);
        lfsr_q     <= lfsr_step(lfsr_q);
        rx_left_q  <= rx_left_q - 32'd1;
        rx_cnt_q   <= rx_cnt_q - BW'(1);
        if (rx_last)
          rx_cnt_q <= bmin(rx_left_q - 32'd1, burst_q);
        cmp_mis_q  <= (readdata_i != pat_word);
        cmp_addr_q <= wa_q;
        cmp_rd_q   <= readdata_i;
        cmp_exp_q  <= pat_word;
      end

      unique case (1'b1)
        (rd_acc && !rx_last): osd_q <= osd_q + OW'(1);
        (rx_last && !rd_acc): osd_q <= osd_q - OW'(1);
        default: ;
      endcase

      if (cmp_v_q && cmp_mis_q) begin
        if (err_cnt_q != '1)
          err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        if (err_cnt_q == '0) begin
          err_addr_q <= cmp_addr_q;
          err_data_q <= cmp_rd_q;
          exp_data_q <= cmp_exp_q;
        end
      end

      if (state_q == S_DRAIN && state_d == S_DONE)
        pass_q <= (err_cnt_q == '0);
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_cnt_q;
  assign err_addr_o   = err_addr_q;
  assign err_data_o   = err_data_q;
  assign exp_data_o   = exp_data_q;
  assign address_o    = addr_q;
  assign burstcount_o = bc_q;
  assign writedata_o  = write_o ? pat_word : '0;
  assign byteenable_o = (read_o || write_o) ?
                        {DATA_B_W{1'b1}} : '0;

endmodule

// File: tb/tb_mem_checker_core.sv
// tb_mem_checker_core: directed bench with Avalon-MM
// slave model for mem_checker_core.
module tb_mem_checker_core;

  localparam int DW = 128;
  localparam int AW = 31;
  localparam int BW = 11;
  localparam int MO = 2;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [31:0]   length_i = '0;
  logic [BW-1:0] burst_i = '0;
  logic [1:0]    mode_i = '0;
  logic [31:0]   pattern_i = '0;
  logic          busy_o, done_o, pass_o;
  logic [EW-1:0] err_cnt_o;
  logic [AW-1:0] err_addr_o;
  logic [DW-1:0] err_data_o, exp_data_o;
  logic [AW-1:0] address_o;
  logic          read_o, write_o;
  logic [DW-1:0] writedata_o;
  logic [BW-1:0] burstcount_o;
  logic [DW/8-1:0] byteenable_o;
  logic          waitrequest_i = 1'b0;
  logic          readdatavalid_i = 1'b0;
  logic [DW-1:0] readdata_i = '0;

  mem_checker_core #(
    .AMM_DATA_W(DW), .AMM_ADDR_W(AW),
    .AMM_BURST_W(BW), .MAX_OUTSTANDING(MO),
    .ERR_CNT_W(EW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .length_i(length_i),
    .burst_i(burst_i), .mode_i(mode_i),
    .pattern_i(pattern_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o),
    .err_data_o(err_data_o), .exp_data_o(exp_data_o),
    .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .writedata_o(writedata_o),
    .burstcount_o(burstcount_o),
    .byteenable_o(byteenable_o),
    .waitrequest_i(waitrequest_i),
    .readdatavalid_i(readdatavalid_i),
    .readdata_i(readdata_i)
  );

  int n_vec = 0;
  int n_mis = 0;

  logic [DW-1:0] mem [256];
  logic          wrand = 1'b0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_a = '0;
  logic          spur = 1'b0;
  int lat = 1;
  int cyc = 0;
  int wbursts, rbursts, rwords, done_cnt;
  int hold_err, rhold_err, max_out, outb;
  int wbeat, wlen, rk;
  logic [AW-1:0] wbase;
  logic          prv_wait;
  logic [AW-1:0] prv_addr;
  logic [AW-1:0] rq_a [$];
  int rq_c [$];
  int rq_t [$];
  int wbc [$];
  int rbc [$];
  logic [AW-1:0] rad [$];

  function automatic logic [DW-1:0] rep(
    input logic [31:0] w
  );
    rep = {(DW/32){w}};
  endfunction

  function automatic logic [31:0] lfsr_n(
    input logic [31:0] s0, input int n
  );
    logic [31:0] s;
    s = s0;
    for (int i = 0; i < n; i++)
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(
    input string tag,
    input logic [DW-1:0] got,
    input logic [DW-1:0] exp
  );
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wbursts = 0; rbursts = 0; rwords = 0;
    done_cnt = 0; hold_err = 0; rhold_err = 0;
    max_out = 0;
    wbc.delete(); rbc.delete(); rad.delete();
  endtask

  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [7:0]    idx;
    logic [DW-1:0] d;
    cyc++;
    if (rst_i) begin
      wbeat = 0; rk = 0; outb = 0;
      rq_a.delete(); rq_c.delete(); rq_t.delete();
      readdatavalid_i = 1'b0;
      readdata_i = '0;
      waitrequest_i = 1'b0;
      prv_wait = 1'b0;
    end else begin
      if (prv_wait &&
          (read_o !== 1'b1 || address_o !== prv_addr))
        rhold_err++;
      waitrequest_i = wrand ?
        1'($urandom_range(0, 1)) : 1'b0;
      if (done_o) done_cnt++;
      if (write_o && !waitrequest_i) begin
        if (wbeat == 0) begin
          wbase = address_o;
          wlen = int'(burstcount_o);
          wbc.push_back(wlen);
          wbursts++;
        end else if (address_o !== wbase ||
                     int'(burstcount_o) != wlen)
          hold_err++;
        a = wbase + AW'(wbeat);
        idx = a[7:0];
        mem[idx] = writedata_o;
        wbeat++;
        if (wbeat == wlen) wbeat = 0;
      end
      if (read_o && !waitrequest_i) begin
        rq_a.push_back(address_o);
        rq_c.push_back(int'(burstcount_o));
        rq_t.push_back(cyc + lat);
        rbc.push_back(int'(burstcount_o));
        rad.push_back(address_o);
        rbursts++;
        outb++;
        if (outb > max_out) max_out = outb;
      end
      prv_wait = read_o && waitrequest_i;
      prv_addr = address_o;
      readdatavalid_i = 1'b0;
      readdata_i = '0;
      if (spur) begin
        readdatavalid_i = 1'b1;
        readdata_i = '1;
      end else if (rq_a.size() > 0 && rq_t[0] <= cyc) begin
        a = rq_a[0] + AW'(rk);
        idx = a[7:0];
        d = mem[idx];
        if (corrupt_en && a == corrupt_a)
          d = d ^ DW'(1);
        readdatavalid_i = 1'b1;
        readdata_i = d;
        rwords++;
        rk++;
        if (rk == rq_c[0]) begin
          void'(rq_a.pop_front());
          void'(rq_c.pop_front());
          void'(rq_t.pop_front());
          rk = 0;
          outb--;
        end
      end
    end
  end

  task automatic run(
    input string tag,
    input logic [1:0] m, input logic [31:0] p,
    input logic [AW-1:0] b, input logic [31:0] l,
    input logic [BW-1:0] bu, input int poke
  );
    int n;
    @(negedge clk);
    clear_logs();
    mode_i = m; pattern_i = p; base_addr_i = b;
    length_i = l; burst_i = bu; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < 5000) begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        start_i = 1'b1; length_i = 32'd3; mode_i = 2'd3;
      end else
        start_i = 1'b0;
    end
    start_i = 1'b0;
    chk({tag, "_done"}, done_o, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_rw", {read_o, write_o}, 0);
    chk("rst_addr", address_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    run("t1", 2'd0, 32'hA5A5_5A5A, '0, 32'd64, 11'd8, 20);
    chk("t1_pass", pass_o, 1);
    chk("t1_err", err_cnt_o, 0);
    repeat (3) @(negedge clk);
    chk("t1_dcnt", done_cnt, 1);
    chk("t1_wb", wbursts, 8);
    chk("t1_rb", rbursts, 8);
    chk("t1_words", rwords, 64);
    chk("t1_mem5", mem[5], rep(32'hA5A5_5A5A));
    chk("t1_hold", hold_err, 0);

    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_err", err_cnt_o, 0);
    chk("spur_pass", pass_o, 1);
    chk("spur_busy", busy_o, 0);

    run("len0", 2'd0, 32'h1234, '0, 32'd0, 11'd8, 0);
    chk("len0_pass", pass_o, 1);
    repeat (3) @(negedge clk);
    chk("len0_bus", wbursts + rbursts, 0);

    run("t2", 2'd1, 32'h0, '0, 32'd10, 11'd4, 0);
    chk("t2_pass", pass_o, 1);
    chk("t2_wn", wbc.size(), 3);
    chk("t2_w0", qget(wbc, 0), 4);
    chk("t2_w1", qget(wbc, 1), 4);
    chk("t2_w2", qget(wbc, 2), 2);
    chk("t2_rn", rbc.size(), 3);
    chk("t2_r0", qget(rbc, 0), 4);
    chk("t2_r2", qget(rbc, 2), 2);
    chk("t2_mem9", mem[9], rep(32'h9));

    run("b0", 2'd1, 32'h0, AW'(32'h40), 32'd3, 11'd0, 0);
    chk("b0_wn", wbc.size(), 3);
    chk("b0_w2", qget(wbc, 2), 1);
    chk("b0_pass", pass_o, 1);

    corrupt_en = 1'b1;
    corrupt_a = AW'(32'h25);
    run("t3", 2'd2, 32'h0, '0, 32'd64, 11'd8, 0);
    chk("t3_err", err_cnt_o, 1);
    chk("t3_eaddr", err_addr_o, 32'h25);
    chk("t3_exp", exp_data_o, rep(lfsr_n(32'h1, 37)));
    chk("t3_rd", err_data_o,
        rep(lfsr_n(32'h1, 37)) ^ DW'(1));
    chk("t3_pass", pass_o, 0);
    chk("t3_mem", mem[8'h25], rep(lfsr_n(32'h1, 37)));
    corrupt_en = 1'b0;

    wrand = 1'b1;
    lat = 20;
    run("t4", 2'd3, 32'h0, AW'(32'h10), 32'd40, 11'd4, 0);
    chk("t4_pass", pass_o, 1);
    chk("t4_err", err_cnt_o, 0);
    chk("t4_maxout", max_out, 2);
    chk("t4_words", rwords, 40);
    chk("t4_rhold", rhold_err, 0);
    chk("t4_whold", hold_err, 0);
    chk("t4_mem", mem[8'h10], rep(32'hFFFF_FFEF));
    wrand = 1'b0;
    lat = 1;

    run("t5", 2'd1, 32'h0, AW'(32'h7FFF_FFFE), 32'd4,
        11'd2, 0);
    chk("t5_pass", pass_o, 1);
    chk("t5_rn", rad.size(), 2);
    chk("t5_a0", (rad.size() > 0) ? rad[0] : '1,
        32'h7FFF_FFFE);
    chk("t5_a1", (rad.size() > 1) ? rad[1] : '1, 0);
    chk("t5_mfe", mem[8'hFE], rep(32'h7FFF_FFFE));
    chk("t5_mff", mem[8'hFF], rep(32'h7FFF_FFFF));
    chk("t5_m00", mem[8'h00], rep(32'h0));
    chk("t5_m01", mem[8'h01], rep(32'h1));

    @(negedge clk);
    mode_i = 2'd0; length_i = 32'd64; burst_i = 11'd8;
    base_addr_i = '0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_inwr", write_o, 1);
    rst_i = 1'b1;
    #1;
    chk("t6_wr0", write_o, 0);
    chk("t6_rd0", read_o, 0);
    chk("t6_busy0", busy_o, 0);
    chk("t6_be0", byteenable_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    run("t6", 2'd0, 32'hA5A5_5A5A, '0, 32'd64, 11'd8, 0);
    chk("t6_pass", pass_o, 1);
    chk("t6_rb", rbursts, 8);

    corrupt_en = 1'b1;
    corrupt_a = AW'(32'h3);
    lat = 20;
    run("t7", 2'd0, 32'hA5A5_5A5A, '0, 32'd64, 11'd8, 0);
    chk("t7_pass", pass_o, 0);
    repeat (10) @(negedge clk);
    chk("t7_dcnt", done_cnt, 1);
`ifdef MEM_CHECKER_STOP_ON_ERR_EN
    chk("t7_stop", rbursts < 8, 1);
    chk("t7_err", err_cnt_o != 0, 1);
`else
    chk("t7_rb", rbursts, 8);
    chk("t7_err", err_cnt_o, 1);
`endif
    chk("t7_eaddr", err_addr_o, 3);
    corrupt_en = 1'b0;
    lat = 1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
